// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction fetches are always word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: redirect target (word aligned) wins over the sequential increment.
module fetch_pc_reg
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] fetch_pc_o
);

  logic [XLEN-1:0] fetch_pc_d;
  logic [XLEN-1:0] fetch_pc_q;

  // Next fetch address selection.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = align_word(redirect_pc_i);
    end else if (inc_i) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: one outstanding imem request, a single holding register
// toward decode, and redirect-driven flushing of in-flight and held words.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_word,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] pend_pc_d, pend_pc_q;
  logic            instr_valid_d, instr_valid_q;
  logic [XLEN-1:0] instr_word_d, instr_word_q;
  logic [XLEN-1:0] instr_pc_d, instr_pc_q;
  logic            instr_fault_d, instr_fault_q;
  logic [XLEN-1:0] fetch_pc;
  logic            req_fire;

  assign imem_req_valid = rst_n & (state_q == FETCH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc_reg (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .inc_i         (req_fire),
    .fetch_pc_o    (fetch_pc)
  );

  // Next-state and holding-register update; redirect overrides every other event.
  always_comb begin
    state_d       = state_q;
    pend_pc_d     = pend_pc_q;
    instr_valid_d = instr_valid_q;
    instr_word_d  = instr_word_q;
    instr_pc_d    = instr_pc_q;
    instr_fault_d = instr_fault_q;
    case (state_q)
      FETCH: begin
        if (req_fire) begin
          pend_pc_d = fetch_pc;
        end else begin
          pend_pc_d = pend_pc_q;
        end
        if (redirect_valid) begin
          state_d = req_fire ? DRAIN : FETCH;
        end else if (req_fire) begin
          state_d = WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rsp_valid ? FETCH : DRAIN;
        end else if (imem_rsp_valid) begin
          instr_word_d  = imem_rsp_data;
          instr_pc_d    = pend_pc_q;
          instr_fault_d = imem_rsp_err;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        // The stale response is discarded whether or not a new redirect arrives.
        if (imem_rsp_valid) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (redirect_valid) begin
      instr_valid_d = 1'b0;
      instr_fault_d = 1'b0;
    end else begin
      instr_valid_d = instr_valid_d;
      instr_fault_d = instr_fault_d;
    end
  end

  // State and decode-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pend_pc_q     <= '0;
      instr_valid_q <= 1'b0;
      instr_word_q  <= NOP_INSTR;
      instr_pc_q    <= '0;
      instr_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_pc_q     <= pend_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_word_q  <= instr_word_d;
      instr_pc_q    <= instr_pc_d;
      instr_fault_q <= instr_fault_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr_word  = instr_word_q;
  assign instr_pc    = instr_pc_q;
  assign instr_fault = instr_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: transaction-level reference model compared
// every cycle, plus hand-computed literal expectations at key points.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_word     (instr_word),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: next address, whether a request is in flight (and whether it is stale),
  // and the instruction handed to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] word;
    logic [31:0] ipc;
    logic        busy;
    logic        stale;
    logic        held;
    logic        fault;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pc = 32'h0; r.req_pc = 32'h0; r.word = 32'h0000_0013; r.ipc = 32'h0;
    r.busy = 1'b0; r.stale = 1'b0; r.held = 1'b0; r.fault = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c);
    model_t n;
    logic   can_req;
    logic   got_rsp;
    n       = c;
    can_req = !c.busy && !c.held;
    got_rsp = c.busy && imem_rsp_valid;
    if (redirect_valid) begin
      n.held  = 1'b0;
      n.fault = 1'b0;
      n.pc    = redirect_pc & 32'hFFFF_FFFC;
      if (got_rsp) begin
        n.busy = 1'b0; n.stale = 1'b0;
      end else if (c.busy) begin
        n.stale = 1'b1;
      end else if (can_req && imem_req_ready) begin
        n.busy = 1'b1; n.stale = 1'b1;
      end
    end else if (can_req && imem_req_ready) begin
      n.busy = 1'b1; n.stale = 1'b0; n.req_pc = c.pc; n.pc = c.pc + 32'd4;
    end else if (got_rsp) begin
      n.busy = 1'b0; n.stale = 1'b0;
      if (!c.stale) begin
        n.held = 1'b1; n.word = imem_rsp_data; n.ipc = c.req_pc; n.fault = imem_rsp_err;
      end
    end else if (c.held && instr_ready) begin
      n.held = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, rst_n && !m.busy && !m.held});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m.held});
    chk("instr_word", instr_word, m.word);
    chk("instr_pc", instr_pc, m.ipc);
    chk("instr_fault", {31'd0, instr_fault}, {31'd0, m.fault});
    if (imem_req_valid) chk("req_addr", imem_req_addr, m.pc);
  end

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd, input logic re,
                     input logic rdir, input logic [31:0] rpc, input logic ir);
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd; imem_rsp_err = re;
    redirect_valid = rdir; redirect_pc = rpc; instr_ready = ir;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst instr_word", instr_word, 32'h0000_0013);
    chk("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first req_addr", imem_req_addr, 32'h0);
    @(negedge clk);

    // First fetch: handshake, 1-cycle response, visible two cycles after handshake.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_006F, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1 instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1 instr_word", instr_word, 32'h0000_006F);
    chk("t1 instr_pc", instr_pc, 32'h0);

    // Decode backpressure for 5 cycles while memory would accept.
    repeat (5) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("bp instr_word", instr_word, 32'h0000_006F);
    chk("bp no req", {31'd0, imem_req_valid}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("bp next addr", imem_req_addr, 32'h4);

    // Zero-wait fetch at 0x4 with decode always ready.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0040_0093, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2 instr_pc", instr_pc, 32'h4);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Memory stall: address holds at 0x8.
    repeat (3) idle();
    chk("stall addr", imem_req_addr, 32'h8);
    chk("stall req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Redirect to 0x1002 while waiting: stale response dropped, then fetch at 0x1000.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1002, 1'b0);
    idle();
    chk("drain no req", {31'd0, imem_req_valid}, 32'd0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drain drop", {31'd0, instr_valid}, 32'd0);
    chk("drain target", imem_req_addr, 32'h0000_1000);

    // Redirect coinciding with decode handshake drops the instruction.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3 instr_pc", instr_pc, 32'h0000_1000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2000, 1'b1);
    chk("hold redir valid", {31'd0, instr_valid}, 32'd0);
    chk("hold redir addr", imem_req_addr, 32'h0000_2000);

    // Faulting access at 0x10 flows to decode; fetch continues at 0x14.
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("fault flag", {31'd0, instr_fault}, 32'd1);
    chk("fault pc", instr_pc, 32'h10);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("fault next", imem_req_addr, 32'h14);

    // Redirect in the same cycle as a request handshake: old request drained.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    chk("fetch redir drain", {31'd0, imem_req_valid}, 32'd0);
    cyc(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("fetch redir addr", imem_req_addr, 32'h300);

    // Wrap from 0xFFFFFFFC to 0x0.
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("wrap start", imem_req_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap pc", instr_pc, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap next", imem_req_addr, 32'h0);

    // Redirects in DRAIN retarget; redirect with response in WAIT drops it.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0060, 1'b0);
    cyc(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    chk("drain retarget", imem_req_addr, 32'h80);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b1, 32'h0000_0090, 1'b0);
    chk("wait redir rsp valid", {31'd0, instr_valid}, 32'd0);
    chk("wait redir rsp addr", imem_req_addr, 32'h90);

    // Back-to-back zero-wait fetches with decode tied ready.
    repeat (6) cyc(1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("async rst req", {31'd0, imem_req_valid}, 32'd0);
    chk("async rst valid", {31'd0, instr_valid}, 32'd0);
    chk("async rst word", instr_word, 32'h0000_0013);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the single-issue RV32I core.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel plus a response channel.
- Registers each returned word with its PC and hands it to the decode/immediate-generator stage over a valid/ready handshake.
- Accepts a redirect (jump/branch target) from execute, which flushes in-flight and held instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- XLEN, 32, width of PC and instruction word (fixed at 32 for RV32I).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_rsp_valid  input  1  response word present this cycle.
- imem_rsp_data  input  XLEN  returned instruction word.
- imem_rsp_err  input  1  access fault for this response.
- redirect_valid  input  1  PC redirect from execute.
- redirect_pc  input  XLEN  redirect target.
- instr_valid  output  1  instr_word/instr_pc/instr_fault valid to decode.
- instr_ready  input  1  decode consumes the instruction this cycle.
- instr_word  output  XLEN  fetched instruction word.
- instr_pc  output  XLEN  address of instr_word.
- instr_fault  output  1  instr_word came from a faulting access.

Behaviour:
- Reset (rst_n=0, async):
  - state=FETCH, fetch_pc=RESET_PC, pend_pc=0.
  - instr_valid=0, instr_word=32'h0000_0013 (NOP), instr_pc=0, instr_fault=0.
  - imem_req_valid is forced 0 while rst_n=0.
- States:
  - FETCH: imem_req_valid=1, imem_req_addr=fetch_pc.
  - WAIT: one request outstanding, waiting for a response.
  - HOLD: instr_valid=1, waiting for instr_ready.
  - DRAIN: one request outstanding whose response must be discarded.
- At most one request outstanding. imem_rsp_valid is ignored in FETCH and HOLD.
- FETCH with imem_req_ready=1: pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps mod 2^32), go to WAIT.
- FETCH without ready: imem_req_valid and imem_req_addr hold stable.
- WAIT with imem_rsp_valid=1:
  - instr_word<=imem_rsp_data, instr_pc<=pend_pc, instr_fault<=imem_rsp_err, go to HOLD.
  - instr_valid rises the next cycle.
- HOLD with instr_ready=1: instr_valid<=0, go to FETCH. Outputs are stable while instr_valid=1 and instr_ready=0.
- DRAIN with imem_rsp_valid=1: response dropped, outputs unchanged, go to FETCH.
- Redirect has priority over every other event in every state:
  - fetch_pc<=redirect_pc with bits [1:0] forced to 00.
  - instr_valid<=0 and instr_fault<=0; a held instruction is dropped even if instr_ready=1 in the same cycle.
- Next state after redirect:
  - FETCH without req handshake: FETCH.
  - FETCH with req handshake in the same cycle: DRAIN; the old-address request is outstanding.
  - WAIT without rsp: DRAIN.
  - WAIT with rsp in the same cycle: response dropped, go to FETCH.
  - HOLD: FETCH.
  - DRAIN without rsp: stay DRAIN, retarget fetch_pc.
  - DRAIN with rsp in the same cycle: response dropped, go to FETCH with the new pc.
- Latency:
  - Redirect at cycle N (no drain): imem_req_addr=new target at N+1.
  - Request handshake at N, response at M≥N+1: instr_valid=1 at M+1.
  - Peak throughput is one instruction per 3 cycles with zero-wait memory and instr_ready tied high.
- Faulting responses flow to decode like normal words. No retry; fetch continues sequentially.

Decomposition:
- Package rv_fetch_pkg:
  - state enum {FETCH, WAIT, HOLD, DRAIN}.
  - NOP_INSTR=32'h0000_0013.
  - PC_INC=4.
  - Default RESET_PC.
- Sub-module fetch_pc_reg: owns fetch_pc. Inputs are redirect (with alignment mask), increment-on-handshake, and reset value. Priority: redirect > increment.

Test Plan:
- Reset release with imem_req_ready=1 and a 1-cycle response returning 32'h0000_006F -> first request addr 0x0. instr_valid=1 with instr_pc=0 and instr_word=0x0000006F two cycles after the handshake. Next request addr 0x4.
- Backpressure: instr_ready=0 for 5 cycles -> instr_valid stays 1, outputs stable, no new imem request. instr_ready=1 -> FETCH next cycle at the following pc.
- Memory stall: imem_req_ready=0 for 3 cycles -> imem_req_addr stays 0x8, fetch_pc does not advance.
- Redirect to 0x0000_1002 while in WAIT -> DRAIN. The stale response is dropped (instr_valid stays 0), then a request is issued at 0x0000_1000.
- Redirect in the same cycle as instr_valid=1 and instr_ready=1 -> instruction dropped. The next request is at the redirect target, not pc+4.
- imem_rsp_err=1 on the response for 0x10 -> instr_fault=1 with instr_pc=0x10. The next fetch is at 0x14. Also check wrap: fetch_pc=0xFFFF_FFFC increments to 0x0.
